ddr_host_ctrl: RTL and testbench
================================

Name: ddr_host_ctrl

Overview:
- Initiator-side sequencer that drives the 8-entry x 8-bit memory interface (wr, rd, wr_add, rd_add, data_in in; data_out out).
- Accepts read/write commands from a client over a valid/ready port and buffers them in a small in-order FIFO.
- Issues each command as a correctly timed strobe on the memory interface and returns read data on a valid/ready response port.
- Sits between any client logic and the memory block so clients no longer hand-drive strobes and addresses.

Parameters:
- ADDR_W, 3, memory address width (8 locations).
- DATA_W, 8, data width.
- FIFO_DEPTH, 4, command FIFO entries (power of two, >=2).
- RD_LAT, 1, cycles from the edge ending the mem_rd cycle to mem_data_out being valid (0 = combinational read).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  client command valid.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  client accepts the response.
- rsp_data  out  DATA_W  read data.
- rsp_addr  out  ADDR_W  address the read data came from.
- mem_wr  out  1  write strobe to the memory.
- mem_rd  out  1  read strobe to the memory.
- mem_wr_add  out  ADDR_W  write address.
- mem_rd_add  out  ADDR_W  read address.
- mem_data_in  out  DATA_W  write data.
- mem_data_out  in  DATA_W  read data from the memory.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset (async assert, sync release): FIFO emptied and pointers cleared; FSM to IDLE. All outputs 0 except cmd_ready = 1. Any in-flight command or response is discarded, with no further strobes.
- FIFO push: on cmd_valid && cmd_ready.
  - cmd_ready = !full, derived from registered occupancy.
  - No same-cycle push bypass when full, even if a pop occurs in that cycle.
  - Simultaneous push and pop when neither full nor empty: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WRITE, READ, WAIT, RESP. All mem_* and rsp_* outputs are registered.
- IDLE:
  - FIFO empty: stay in IDLE.
  - Head is a write: pop it → WRITE.
  - Head is a read: pop it → READ.
- WRITE: exactly one cycle with mem_wr = 1, mem_wr_add = addr, mem_data_in = wdata.
  - If the FIFO is non-empty at the end of the cycle, pop the next command directly. A write head goes back to WRITE, giving 1 write/cycle throughput. A read head goes to READ.
  - Otherwise → IDLE.
- READ: one cycle with mem_rd = 1 and mem_rd_add = addr.
  - RD_LAT = 0 → sample mem_data_out at the end of READ.
  - Otherwise → WAIT.
- WAIT:
  - mem_rd = 0; mem_rd_add is held stable.
  - A counter counts RD_LAT cycles; mem_data_out is sampled at the edge ending the last WAIT cycle.
- Read timing: command popped at edge E1 → data sampled at edge E(2+RD_LAT). rsp_valid rises at that edge, with rsp_data and rsp_addr loaded → RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_addr are held constant until rsp_ready = 1.
  - On acceptance rsp_valid clears at the next edge and the FSM returns to IDLE; no new command issues in the acceptance cycle.
  - Reads are therefore blocking, and ordering is strictly in command order. A read after a write to the same address always returns the new data.
- Idle values: when mem_wr = 0, mem_wr_add and mem_data_in are 0. mem_rd_add is 0 outside READ/WAIT. mem_wr and mem_rd are never both 1.
- FIFO pushes continue while the FSM is in WAIT/RESP, until the FIFO is full.
- busy = (count != 0) || (state != IDLE).

Test Plan:
- Reset then write (addr 1, 8'h1D) → one cycle with mem_wr = 1, mem_wr_add = 1, mem_data_in = 8'h1D at E1 after push; busy falls 1 cycle later.
- Writes (1, 8'h1D) and (2, 8'h01) pushed back-to-back, then reads 1 and 2, with rsp_ready = 1 and RD_LAT = 1 → mem_wr on 2 consecutive cycles; responses 8'h1D/addr 1 then 8'h01/addr 2; each rsp_valid is 1 cycle and appears 3 edges after its pop.
- Read addr 3 with rsp_ready held 0 for 5 cycles → rsp_valid stays 1 with rsp_data stable; no mem strobe occurs; with cmd_valid held 1, cmd_ready drops after 4 pushes; after rsp_ready rises, the next command issues.
- Write (3, 8'h07) immediately followed by read 3 → response 8'h07; repeat with RD_LAT = 0 and RD_LAT = 3 → sample edge at E2 and E5 respectively.
- Fill FIFO (4 cmds), then push again while the FSM pops → cmd_ready = 0 in the full cycle, and the 5th command is accepted only on the next cycle; no command is lost or duplicated over 6 entries (pointer wrap).
- Assert reset during WAIT with 2 commands queued → all outputs 0 immediately (async); after release, no strobes and no rsp_valid occur until a new command is pushed.

Source files
------------

// File: rtl/ddr_host_ctrl.sv
// Client-side sequencer for the 8x8 memory: queues commands, issues timed strobes, returns read data in order.
// Pop->rsp_valid is 2+RD_LAT edges; cmd_ready falls when the FIFO is full; responses hold until rsp_ready.

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  // Full comes from registered occupancy only, so a pop never frees a slot in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = store[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_dat;
  end
endmodule

module ddr_host_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_wr_add,
  output logic [ADDR_W-1:0] mem_rd_add,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] LAST = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

  state_t        state;
  cmd_t          push_cmd, head;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [CW-1:0] lat_cnt;

  assign push_cmd  = {cmd_we, cmd_addr, cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = !fifo_empty && (state == IDLE || state == WRITE);
  assign busy      = !fifo_empty || (state != IDLE);

  sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (cmd_valid),
    .push_dat (push_cmd),
    .pop      (fifo_pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr_add  <= '0;
      mem_rd_add  <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_addr    <= '0;
    end else begin
      mem_wr      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr_add  <= '0;
      mem_data_in <= '0;
      case (state)
        // WRITE pops straight into the next command for back-to-back writes.
        IDLE, WRITE: begin
          if (fifo_pop) begin
            if (head.we) begin
              mem_wr      <= 1'b1;
              mem_wr_add  <= head.addr;
              mem_data_in <= head.wdata;
              state       <= WRITE;
            end else begin
              mem_rd     <= 1'b1;
              mem_rd_add <= head.addr;
              state      <= READ;
            end
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (RD_LAT == 0) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= mem_data_out;
            rsp_addr   <= mem_rd_add;
            mem_rd_add <= '0;
            state      <= RESP;
          end else begin
            lat_cnt <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == LAST) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= mem_data_out;
            rsp_addr   <= mem_rd_add;
            mem_rd_add <= '0;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt + CW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddr_host_ctrl.sv
// Three controllers (RD_LAT 1, 0, 3) each on a behavioural memory; directed steps with a read scoreboard.
module tb_ddr_host_ctrl;
  localparam logic [29:0] RST_VEC = 30'h2000_0000;

  typedef struct {
    int         idx;
    logic [2:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_we;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       cmd_valid [3];
  logic       cmd_ready [3];
  logic       rsp_valid [3];
  logic       rsp_ready [3];
  logic [7:0] rsp_data [3];
  logic [2:0] rsp_addr [3];
  logic       mem_wr [3];
  logic       mem_rd [3];
  logic [2:0] mem_wr_add [3];
  logic [2:0] mem_rd_add [3];
  logic [7:0] mem_data_in [3];
  logic       busy [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt [3];
  int rd_cnt [3];
  int rd_cyc [3];
  int run [3];
  int last_run [3];
  int rsp_rises [3];
  bit prev_v [3];
  logic [7:0] prev_d [3];
  logic [2:0] prev_a [3];
  logic [7:0] ref_mem [3][8];
  exp_t exp_q [$];
  int s_wr, s_rd, s_rise;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [7:0] mem [8];
    logic [7:0] pipe [4];
    logic [7:0] mdo;

    ddr_host_ctrl #(.ADDR_W(3), .DATA_W(8), .FIFO_DEPTH(4), .RD_LAT(LAT)) u_dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid[g]),
      .cmd_ready    (cmd_ready[g]),
      .cmd_we       (cmd_we),
      .cmd_addr     (cmd_addr),
      .cmd_wdata    (cmd_wdata),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_data     (rsp_data[g]),
      .rsp_addr     (rsp_addr[g]),
      .mem_wr       (mem_wr[g]),
      .mem_rd       (mem_rd[g]),
      .mem_wr_add   (mem_wr_add[g]),
      .mem_rd_add   (mem_rd_add[g]),
      .mem_data_in  (mem_data_in[g]),
      .mem_data_out (mdo),
      .busy         (busy[g])
    );

    // Read data is only valid RD_LAT edges after the strobe cycle; any other sample sees 8'hEE.
    always @(posedge clock) begin
      if (mem_wr[g]) mem[mem_wr_add[g]] <= mem_data_in[g];
      pipe[0] <= mem_rd[g] ? mem[mem_rd_add[g]] : 8'hEE;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mdo = (LAT == 0) ? (mem_rd[g] ? mem[mem_rd_add[g]] : 8'hEE) : pipe[(LAT == 0) ? 0 : LAT - 1];
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
  endfunction

  function automatic logic [29:0] outs(input int i);
    return {cmd_ready[i], rsp_valid[i], rsp_data[i], rsp_addr[i], mem_wr[i], mem_rd[i],
            mem_wr_add[i], mem_rd_add[i], mem_data_in[i], busy[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic monitor_step();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        prev_v[i] = 1'b0;
        run[i] = 0;
      end else begin
        if (mem_wr[i]) begin
          wr_cnt[i]++;
          run[i]++;
        end else begin
          if (run[i] != 0) last_run[i] = run[i];
          run[i] = 0;
          check("wr_idle_zero", {mem_wr_add[i], mem_data_in[i]}, 0);
        end
        if (mem_rd[i]) begin
          rd_cnt[i]++;
          rd_cyc[i] = cyc;
          check("strobe_excl", mem_wr[i], 0);
        end
        // rsp_ready only changes right after a sample, so its current value is the one the edge saw.
        if (prev_v[i] && rsp_ready[i]) begin
          check("rsp_pulse", rsp_valid[i], 0);
          check("rsp_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_inst", i, e.idx);
            check("rsp_addr", prev_a[i], e.addr);
            check("rsp_data", prev_d[i], e.data);
          end
        end
        if (rsp_valid[i] && !prev_v[i]) begin
          rsp_rises[i]++;
          check("rsp_lat", cyc - rd_cyc[i], 1 + lat_of(i));
        end
        prev_v[i] = rsp_valid[i];
        prev_d[i] = rsp_data[i];
        prev_a[i] = rsp_addr[i];
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    monitor_step();
  endtask

  task automatic push(input int i, input bit we, input int a, input int d);
    int n;
    exp_t e;
    n = 0;
    cmd_valid[i] = 1'b1;
    cmd_we = we;
    cmd_addr = 3'(a);
    cmd_wdata = 8'(d);
    while (!cmd_ready[i] && n < 100) begin
      tick();
      n++;
    end
    check("push_accept", n < 100, 1);
    if (we) begin
      ref_mem[i][a] = 8'(d);
    end else begin
      e.idx = i;
      e.addr = 3'(a);
      e.data = ref_mem[i][a];
      exp_q.push_back(e);
    end
    tick();
    cmd_valid[i] = 1'b0;
  endtask

  task automatic drain(input int i, input string tag);
    int n;
    n = 0;
    tick();
    while ((busy[i] || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check(tag, n < 300, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      cmd_valid[i] = 1'b0;
      rsp_ready[i] = 1'b1;
      wr_cnt[i] = 0; rd_cnt[i] = 0; rd_cyc[i] = 0; run[i] = 0;
      last_run[i] = 0; rsp_rises[i] = 0; prev_v[i] = 1'b0;
      prev_d[i] = '0; prev_a[i] = '0;
      for (int a = 0; a < 8; a++) ref_mem[i][a] = 8'h00;
    end
    cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0;

    // Reset values, during and after reset.
    repeat (3) tick();
    for (int i = 0; i < 3; i++) check("reset_outs", outs(i), RST_VEC);
    reset = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) check("post_reset_outs", outs(i), RST_VEC);

    // Single write: strobe one cycle after the push edge, busy clears the cycle after.
    push(0, 1, 1, 'h1D);
    check("t1_no_wr_yet", mem_wr[0], 0);
    check("t1_busy", busy[0], 1);
    tick();
    check("t1_wr", mem_wr[0], 1);
    check("t1_wr_add", mem_wr_add[0], 1);
    check("t1_wr_dat", mem_data_in[0], 'h1D);
    tick();
    check("t1_wr_end", mem_wr[0], 0);
    check("t1_busy_fall", busy[0], 0);

    // Back-to-back writes then two reads.
    s_rise = rsp_rises[0];
    push(0, 1, 1, 'h1D);
    push(0, 1, 2, 'h01);
    push(0, 0, 1, 0);
    push(0, 0, 2, 0);
    drain(0, "t2_drain");
    check("t2_wr_run", last_run[0], 2);
    check("t2_rsp_count", rsp_rises[0] - s_rise, 2);

    // Stalled response with the FIFO filling behind it.
    rsp_ready[0] = 1'b0;
    s_wr = wr_cnt[0];
    push(0, 1, 3, 'h5C);
    push(0, 0, 3, 0);
    push(0, 1, 4, 'h44);
    push(0, 1, 5, 'h55);
    push(0, 0, 4, 0);
    push(0, 0, 5, 0);
    check("t3_full", cmd_ready[0], 0);
    s_wr = wr_cnt[0];
    s_rd = rd_cnt[0];
    cmd_valid[0] = 1'b1; cmd_we = 1'b0; cmd_addr = 3'd3;
    for (int k = 0; k < 5; k++) begin
      check("t3_hold_vld", rsp_valid[0], 1);
      check("t3_hold_dat", rsp_data[0], 'h5C);
      check("t3_hold_add", rsp_addr[0], 3);
      check("t3_hold_rdy", cmd_ready[0], 0);
      tick();
    end
    check("t3_no_wr", wr_cnt[0] - s_wr, 0);
    check("t3_no_rd", rd_cnt[0] - s_rd, 0);
    rsp_ready[0] = 1'b1;
    push(0, 0, 3, 0);
    drain(0, "t3_drain");
    check("t3_writes_after", wr_cnt[0] - s_wr, 2);

    // Write then read of the same address on each read latency.
    for (int i = 0; i < 3; i++) begin
      push(i, 1, 3, 'h07);
      push(i, 0, 3, 0);
      drain(i, "t4_drain");
    end

    // Full FIFO: no bypass in the pop cycle, fifth command taken one cycle later.
    rsp_ready[0] = 1'b0;
    push(0, 0, 1, 0);
    push(0, 1, 0, 'h11);
    push(0, 1, 1, 'h22);
    push(0, 1, 2, 'h33);
    push(0, 1, 3, 'h44);
    check("t5_full", cmd_ready[0], 0);
    s_wr = wr_cnt[0];
    cmd_valid[0] = 1'b1; cmd_we = 1'b0; cmd_addr = 3'd2;
    rsp_ready[0] = 1'b1;
    tick();
    check("t5_pop_cycle_rdy", cmd_ready[0], 0);
    check("t5_rsp_done", rsp_valid[0], 0);
    tick();
    check("t5_rdy_back", cmd_ready[0], 1);
    check("t5_pop_wr", mem_wr[0], 1);
    check("t5_pop_addr", mem_wr_add[0], 0);
    begin
      exp_t e;
      e.idx = 0; e.addr = 3'd2; e.data = ref_mem[0][2];
      exp_q.push_back(e);
    end
    tick();
    cmd_valid[0] = 1'b0;
    push(0, 0, 0, 0);
    drain(0, "t5_drain");
    check("t5_writes", wr_cnt[0] - s_wr, 4);

    // Reset during WAIT with two reads queued.
    push(2, 0, 3, 0);
    push(2, 0, 3, 0);
    push(2, 0, 3, 0);
    check("t6_wait_rd", mem_rd[2], 0);
    check("t6_wait_add", mem_rd_add[2], 3);
    check("t6_wait_busy", busy[2], 1);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check("t6_async_reset", outs(i), RST_VEC);
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    s_wr = wr_cnt[2];
    s_rd = rd_cnt[2];
    s_rise = rsp_rises[2];
    repeat (10) tick();
    check("t6_no_wr", wr_cnt[2] - s_wr, 0);
    check("t6_no_rd", rd_cnt[2] - s_rd, 0);
    check("t6_no_rsp", rsp_rises[2] - s_rise, 0);
    check("t6_idle_outs", outs(2), RST_VEC);
    push(2, 1, 6, 'h66);
    push(2, 0, 6, 0);
    drain(2, "t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
